// File: rtl/prio_encoder_rr_pkg.sv
// Shared definitions for the round-robin priority encoder: mode encodings and
// modulo-N index arithmetic used by the search and pointer logic.
package prio_encoder_rr_pkg;

   localparam logic MODE_FIXED = 1'b0;
   localparam logic MODE_RR    = 1'b1;

   // (a - b) mod n, with a and b already in [0, n)
   function automatic int unsigned dec_mod(int unsigned a, int unsigned b, int unsigned n);
      return (a + n - b) % n;
   endfunction

endpackage

// File: rtl/prio_pick.sv
// Combinational pick: first set request searching downward from start, wrapping 0 -> N-1.
// Rotates the request vector so the search order becomes a plain lowest-offset encode.
module prio_pick
   import prio_encoder_rr_pkg::*;
#(
   parameter  int unsigned N = 8,
   localparam int unsigned W = $clog2(N)
) (
   input  logic [N-1:0] req,
   input  logic [W-1:0] start,
   output logic [W-1:0] idx,
   output logic         any
);

   logic [N-1:0] w_rot;
   int unsigned  w_off;

   always_comb begin
      w_rot = '0;
      w_off = 0;
      // w_rot[d] is the request d steps below start
      for (int d = 0; d < int'(N); d++) begin
         w_rot[d] = req[W'(dec_mod(32'(start), d, N))];
      end
      for (int d = int'(N) - 1; d >= 0; d--) begin
         if (w_rot[d]) begin
            w_off = d;
         end
      end
      any = |req;
      idx = W'(dec_mod(32'(start), w_off, N));
   end

endmodule

// File: rtl/prio_encoder_rr.sv
// Registered priority encoder with fixed or round-robin priority and a valid/ready
// output stage; holds the result register, the priority pointer and the handshake.
module prio_encoder_rr
   import prio_encoder_rr_pkg::*;
#(
   parameter  int unsigned N = 8,
   localparam int unsigned W = $clog2(N)
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         en,
   input  logic         mode,
   input  logic [N-1:0] req,
   input  logic         out_ready,
   output logic         out_valid,
   output logic [W-1:0] out_idx,
   output logic [W-1:0] ptr
);

   localparam logic [W-1:0] LAST_IDX = W'(N - 1);

   logic         r_valid;
   logic         r_mode;
   logic [W-1:0] r_idx;
   logic [W-1:0] r_ptr;

   logic         w_accept;
   logic         w_cap;
   logic         w_any;
   logic [W-1:0] w_ptr_nxt;
   logic [W-1:0] w_start;
   logic [W-1:0] w_win;

   assign w_accept = r_valid && out_ready;

   // The pointer advanced by this cycle's acceptance seeds a same-cycle capture,
   // so back-to-back round-robin results rotate without a bubble.
   always_comb begin
      w_ptr_nxt = r_ptr;
      if (w_accept && (r_mode == MODE_RR)) begin
         w_ptr_nxt = (r_idx == '0) ? LAST_IDX : r_idx - 1'b1;
      end
      w_start = (mode == MODE_FIXED) ? LAST_IDX : w_ptr_nxt;
   end

   prio_pick #(
      .N (N)
   ) u_pick (
      .req   (req),
      .start (w_start),
      .idx   (w_win),
      .any   (w_any)
   );

   assign w_cap = en && w_any && (!r_valid || out_ready);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= 1'b0;
         r_mode  <= MODE_FIXED;
         r_idx   <= '0;
         r_ptr   <= LAST_IDX;
      end else begin
         r_ptr <= w_ptr_nxt;
         if (w_cap) begin
            r_valid <= 1'b1;
            r_idx   <= w_win;
            r_mode  <= mode;
         end else if (w_accept) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign out_valid = r_valid;
   assign out_idx   = r_idx;
   assign ptr       = r_ptr;

endmodule

// File: tb/tb_prio_encoder_rr.sv
// Bench for prio_encoder_rr: N=8 and N=5 instances share control inputs, a
// transaction-level model feeds per-instance scoreboards checked by a negedge monitor.
module tb_prio_encoder_rr;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       en = 1'b0;
   logic       mode = 1'b0;
   logic       out_ready = 1'b0;
   logic [7:0] req8 = '0;
   logic [4:0] req5 = '0;
   logic       v8, v5;
   logic [2:0] i8, p8, i5, p5;

   int total = 0;
   int bad = 0;

   int m_valid[2];
   int m_idx[2];
   int m_ptr[2];
   int m_mode[2];
   int q0[$];
   int q1[$];

   int exp_i[5] = '{7, 2, 0, 7, 2};
   int exp_p[5] = '{7, 6, 1, 7, 6};

   prio_encoder_rr #(.N(8)) u_dut8 (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .req       (req8),
      .out_ready (out_ready),
      .out_valid (v8),
      .out_idx   (i8),
      .ptr       (p8)
   );

   prio_encoder_rr #(.N(5)) u_dut5 (
      .clk       (clk),
      .rst_n     (rst_n),
      .en        (en),
      .mode      (mode),
      .req       (req5),
      .out_ready (out_ready),
      .out_valid (v5),
      .out_idx   (i5),
      .ptr       (p5)
   );

   always #5 clk = ~clk;

   task automatic chk(string name, int act, int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Walk downward from start, wrapping, and return the first requester found.
   function automatic int search(logic [7:0] r, int start, int n);
      for (int k = 0; k < n; k++) begin
         int j;
         j = (start - k + n) % n;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 2; i++) begin
         m_valid[i] = 0;
         m_idx[i]   = 0;
         m_mode[i]  = 0;
      end
      m_ptr[0] = 7;
      m_ptr[1] = 4;
      q0.delete();
      q1.delete();
   endtask

   task automatic model_step(int i, int n, logic [7:0] r);
      bit acc;
      int w;
      acc = (m_valid[i] != 0) && out_ready;
      if (acc && m_mode[i] == 1) m_ptr[i] = (m_idx[i] == 0) ? n - 1 : m_idx[i] - 1;
      if (en && r != 0 && (m_valid[i] == 0 || out_ready)) begin
         w = search(r, mode ? m_ptr[i] : n - 1, n);
         m_idx[i]   = w;
         m_mode[i]  = int'(mode);
         m_valid[i] = 1;
         if (i == 0) q0.push_back(w);
         else q1.push_back(w);
      end else if (acc) begin
         m_valid[i] = 0;
      end
   endtask

   task automatic cyc(logic e, logic m, logic [7:0] r, logic rd);
      en        = e;
      mode      = m;
      req8      = r;
      req5      = r[4:0];
      out_ready = rd;
      @(posedge clk);
      #1;
      model_step(0, 8, r);
      model_step(1, 5, {3'b000, r[4:0]});
   endtask

   task automatic mon(int i, logic v, logic [2:0] idx, logic [2:0] p);
      string s;
      int    qs;
      s  = (i == 0) ? "n8" : "n5";
      qs = (i == 0) ? q0.size() : q1.size();
      chk({s, "_valid"}, int'(v), m_valid[i]);
      chk({s, "_ptr"}, int'(p), m_ptr[i]);
      if (v) begin
         if (qs == 0) begin
            chk({s, "_sb_empty"}, int'(idx), -1);
         end else begin
            chk({s, "_sb_idx"}, int'(idx), (i == 0) ? q0[0] : q1[0]);
            if (out_ready) begin
               if (i == 0) void'(q0.pop_front());
               else void'(q1.pop_front());
            end
         end
      end else begin
         chk({s, "_idx_hold"}, int'(idx), m_idx[i]);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, v8, i8, p8);
         mon(1, v5, i5, p5);
      end
   end

   initial begin
      logic [7:0] r;
      model_reset();
      #2 rst_n = 1'b0;
      #1;
      chk("rst_valid", int'(v8), 0);
      chk("rst_idx", int'(i8), 0);
      chk("rst_ptr8", int'(p8), 7);
      chk("rst_ptr5", int'(p5), 4);
      @(posedge clk);
      @(posedge clk);
      #2 rst_n = 1'b1;

      // fixed priority, held request
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 8'b0010_0110, 1'b1);
      chk("fixed_idx", int'(i8), 5);
      chk("fixed_ptr", int'(p8), 7);

      // round-robin rotation
      for (int k = 0; k < 5; k++) begin
         cyc(1'b1, 1'b1, 8'b1000_0101, 1'b1);
         chk("rr_idx", int'(i8), exp_i[k]);
         chk("rr_ptr", int'(p8), exp_p[k]);
      end

      // stall with a result of 3 pending while req changes
      cyc(1'b1, 1'b0, 8'b0000_1000, 1'b1);
      for (int k = 0; k < 4; k++) cyc(1'b1, 1'b0, 8'b1000_0000, 1'b0);
      chk("stall_idx", int'(i8), 3);
      chk("stall_valid", int'(v8), 1);
      cyc(1'b1, 1'b0, 8'b1000_0000, 1'b1);
      chk("unstall_idx", int'(i8), 7);

      // en=0 and req=0 block captures
      for (int k = 0; k < 3; k++) cyc(1'b0, 1'b0, 8'b1000_0000, 1'b1);
      for (int k = 0; k < 2; k++) cyc(1'b1, 1'b1, 8'b0000_0000, 1'b1);
      chk("idle_valid", int'(v8), 0);
      cyc(1'b1, 1'b1, 8'b0100_0000, 1'b0);
      cyc(1'b0, 1'b1, 8'b0100_0000, 1'b1);
      cyc(1'b0, 1'b1, 8'b0100_0000, 1'b1);
      chk("en0_drain_valid", int'(v8), 0);

      // pointer wrap after serving index 0
      cyc(1'b1, 1'b1, 8'b0000_0001, 1'b1);
      cyc(1'b1, 1'b1, 8'b0001_0000, 1'b1);
      chk("wrap_ptr5", int'(p5), 4);
      chk("wrap_idx5", int'(i5), 4);
      chk("wrap_ptr8", int'(p8), 7);

      for (int k = 0; k < 300; k++) begin
         r = 8'($urandom);
         if ($urandom_range(0, 4) == 0) r = '0;
         cyc($urandom_range(0, 7) != 0, 1'($urandom), r, $urandom_range(0, 3) != 0);
      end

      // reset while a result is pending
      cyc(1'b1, 1'b0, 8'hFF, 1'b0);
      cyc(1'b1, 1'b0, 8'hFF, 1'b0);
      chk("pre_rst_valid", int'(v8), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_valid", int'(v8), 0);
      chk("midrst_idx", int'(i8), 0);
      chk("midrst_ptr8", int'(p8), 7);
      chk("midrst_ptr5", int'(p5), 4);
      model_reset();
      @(posedge clk);
      #2 rst_n = 1'b1;

      for (int k = 0; k < 200; k++) begin
         r = 8'($urandom);
         if ($urandom_range(0, 4) == 0) r = '0;
         cyc($urandom_range(0, 7) != 0, 1'($urandom), r, $urandom_range(0, 3) != 0);
      end

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
